pac_sprite_gen: RTL and testbench

Parametrised, pipelined Pac-Man sprite pixel generator for the VGA render path. It holds right-facing 16×16 mouth bitmaps and derives the other three directions by mirror or transpose. Screen-space offsets are scaled down by an integer `SCALE`, and an internal mouth-animation sequencer advances only while Pac-Man is moving. It sits between the pixel scanner, which issues per-pixel requests inside the sprite box, and the colour mux.

---
 rtl/pac_sprite_gen.sv | 187 ++++++++++++++++++
 tb/tb_pac_sprite_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pac_sprite_gen.sv
// Pac-Man sprite pixel generator: 2-stage scale/map/lookup pipeline plus a mouth-animation sequencer.
// Optional PAC_CLOSED_FRAME_EN adds the closed-disc frame and a 4-step open/wide/open/closed cycle.
module pac_sprite_gen #(
   parameter int SCALE       = 3,
   parameter int ANIM_PERIOD = 10_000_000,
   parameter int COORD_W     = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         dir,
   input  logic               moving,
   input  logic               req_valid,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic               pixel,
   output logic               pixel_valid,
   output logic [1:0]         frame
);

   localparam int CNT_W = ($clog2(ANIM_PERIOD) > 24) ? $clog2(ANIM_PERIOD) : 24;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ANIM_PERIOD - 1);
   localparam logic [COORD_W:0]   BOX      = (COORD_W + 1)'(16 * SCALE);
   localparam logic [COORD_W-1:0] SCALE_C  = COORD_W'(SCALE);
`ifdef PAC_CLOSED_FRAME_EN
   localparam int PH_W = 2;
`else
   localparam int PH_W = 1;
`endif

   localparam logic [3:0] DIR_L = 4'b1000;
   localparam logic [3:0] DIR_U = 4'b0100;
   localparam logic [3:0] DIR_R = 4'b0010;
   localparam logic [3:0] DIR_D = 4'b0001;

   function automatic logic [15:0] open_row(input logic [3:0] r);
      case (r)
         4'd0:  open_row = 16'h07E0;
         4'd1:  open_row = 16'h0FF0;
         4'd2:  open_row = 16'h1FFC;
         4'd3:  open_row = 16'h3FFC;
         4'd4:  open_row = 16'h7FFE;
         4'd5:  open_row = 16'h0FFE;
         4'd6:  open_row = 16'h01FF;
         4'd7:  open_row = 16'h003F;
         4'd8:  open_row = 16'h003F;
         4'd9:  open_row = 16'h01FF;
         4'd10: open_row = 16'h0FFE;
         4'd11: open_row = 16'h7FFE;
         4'd12: open_row = 16'h3FFC;
         4'd13: open_row = 16'h1FFC;
         4'd14: open_row = 16'h0FF0;
         default: open_row = 16'h03C0;
      endcase
   endfunction

   function automatic logic [15:0] wide_row(input logic [3:0] r);
      case (r)
         4'd0:  wide_row = 16'h07E0;
         4'd1:  wide_row = 16'h0FF0;
         4'd2:  wide_row = 16'h07FC;
         4'd3:  wide_row = 16'h03FC;
         4'd4:  wide_row = 16'h01FE;
         4'd5:  wide_row = 16'h00FE;
         4'd6:  wide_row = 16'h007F;
         4'd7:  wide_row = 16'h003F;
         4'd8:  wide_row = 16'h003F;
         4'd9:  wide_row = 16'h007F;
         4'd10: wide_row = 16'h00FE;
         4'd11: wide_row = 16'h01FE;
         4'd12: wide_row = 16'h03FC;
         4'd13: wide_row = 16'h07FC;
         4'd14: wide_row = 16'h0FF0;
         default: wide_row = 16'h03C0;
      endcase
   endfunction

`ifdef PAC_CLOSED_FRAME_EN
   // Disc centred between rows/cols 7 and 8, evaluated in doubled coordinates to stay integral.
   function automatic logic closed_px(input logic [3:0] r, input logic [3:0] c);
      logic signed [6:0]  dr;
      logic signed [6:0]  dc;
      logic signed [13:0] d2;
      dr = $signed({2'b00, r, 1'b0}) - 7'sd15;
      dc = $signed({2'b00, c, 1'b0}) - 7'sd15;
      d2 = dr * dr + dc * dc;
      closed_px = (d2 <= 14'sd225);
   endfunction

   function automatic logic [1:0] frame_of(input logic [PH_W-1:0] ph);
      case (ph)
         2'd1:    frame_of = 2'd1;
         2'd3:    frame_of = 2'd2;
         default: frame_of = 2'd0;
      endcase
   endfunction
`else
   function automatic logic [1:0] frame_of(input logic [PH_W-1:0] ph);
      frame_of = {1'b0, ph};
   endfunction
`endif

   logic [CNT_W-1:0] anim_cnt;
   logic [PH_W-1:0]  phase;
   logic [PH_W-1:0]  phase_inc;
   logic [3:0]       dir_q;

   assign phase_inc = phase + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         anim_cnt <= '0;
         phase    <= '0;
         frame    <= 2'd0;
         dir_q    <= DIR_R;
      end else begin
         if ($onehot(dir))
            dir_q <= dir;
         if (moving) begin
            if (anim_cnt == CNT_LAST) begin
               anim_cnt <= '0;
               phase    <= phase_inc;
               frame    <= frame_of(phase_inc);
            end else begin
               anim_cnt <= anim_cnt + 1'b1;
            end
         end
      end
   end

   // Stage p1: scale offsets, flag out-of-box, snapshot frame and direction
   logic [3:0] sx_p1;
   logic [3:0] sy_p1;
   logic       oor_p1;
   logic [1:0] frame_p1;
   logic [3:0] dir_p1;
   logic       vld_p1;

   always_ff @(posedge clk) begin
      sx_p1    <= 4'(x / SCALE_C);
      sy_p1    <= 4'(y / SCALE_C);
      oor_p1   <= ({1'b0, x} >= BOX) || ({1'b0, y} >= BOX);
      frame_p1 <= frame;
      dir_p1   <= dir_q;
   end

   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= req_valid;
   end

   // Stage p2: direction mapping and bitmap lookup
   logic [3:0]  r_p1;
   logic [3:0]  c_p1;
   logic [15:0] row_p1;
   logic        bit_p1;

   always_comb begin
      r_p1 = sy_p1;
      c_p1 = sx_p1;
      case (dir_p1)
         DIR_L: begin r_p1 = sy_p1; c_p1 = 4'd15 - sx_p1; end
         DIR_D: begin r_p1 = sx_p1; c_p1 = sy_p1;         end
         DIR_U: begin r_p1 = sx_p1; c_p1 = 4'd15 - sy_p1; end
         default: ;
      endcase
   end

   always_comb begin
      row_p1 = (frame_p1 == 2'd1) ? wide_row(r_p1) : open_row(r_p1);
      bit_p1 = row_p1[c_p1];
`ifdef PAC_CLOSED_FRAME_EN
      if (frame_p1 == 2'd2)
         bit_p1 = closed_px(r_p1, c_p1);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pixel       <= 1'b0;
         pixel_valid <= 1'b0;
      end else begin
         pixel       <= bit_p1 & ~oor_p1;
         pixel_valid <= vld_p1;
      end
   end

endmodule

// File: tb/tb_pac_sprite_gen.sv
// Directed bench for pac_sprite_gen (SCALE=3, ANIM_PERIOD=4); honours PAC_CLOSED_FRAME_EN.
module tb_pac_sprite_gen;

   localparam int COORD_W = 6;
   localparam logic [3:0] DL = 4'b1000, DU = 4'b0100, DR = 4'b0010;
`ifdef PAC_CLOSED_FRAME_EN
   localparam logic [1:0] F_THIRD = 2'd2;
`else
   localparam logic [1:0] F_THIRD = 2'd1;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [3:0]         dir;
   logic               moving;
   logic               req_valid;
   logic [COORD_W-1:0] x, y;
   logic               pixel, pixel_valid;
   logic [1:0]         frame;

   int checks = 0;
   int errors = 0;

   pac_sprite_gen #(.SCALE(3), .ANIM_PERIOD(4), .COORD_W(COORD_W)) dut (
      .clk(clk), .rst(rst), .dir(dir), .moving(moving), .req_valid(req_valid),
      .x(x), .y(y), .pixel(pixel), .pixel_valid(pixel_valid), .frame(frame)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One request, result must appear exactly two edges later.
   task automatic do_req(input string tag, input int xi, input int yi, input logic exp);
      x = COORD_W'(xi);
      y = COORD_W'(yi);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk({tag, "_vld_early"}, pixel_valid, 0);
      step();
      chk({tag, "_vld"}, pixel_valid, 1);
      chk({tag, "_pix"}, pixel, exp);
   endtask

   logic [8:0] pv_hist;
   int         pv_ones;

   initial begin
      rst = 1'b1; dir = 4'b0000; moving = 1'b0; req_valid = 1'b0; x = '0; y = '0;
      step(); step();
      rst = 1'b0;
      chk("rst_pv", pixel_valid, 0);
      chk("rst_pix", pixel, 0);
      chk("rst_frame", frame, 0);
      chk("rst_dir", dut.dir_q, DR);

      do_req("R_15_21", 15, 21, 1'b1);
      do_req("R_45_21", 45, 21, 1'b0);

      dir = DL; step(); dir = 4'b0000;
      do_req("L_0_21", 0, 21, 1'b0);
      do_req("L_45_21", 45, 21, 1'b1);

      dir = 4'b0110; step();
      chk("bad_dir_hold", dut.dir_q, DL);
      do_req("L2_0_21", 0, 21, 1'b0);

      dir = DU; step(); dir = 4'b0000;
      do_req("U_21_0", 21, 0, 1'b0);
      do_req("U_21_45", 21, 45, 1'b1);

      dir = DR; step(); dir = 4'b0000;
      do_req("oor_x48", 48, 5, 1'b0);
      do_req("oor_y48", 5, 48, 1'b0);

      // three-request burst
      x = 6'd15; y = 6'd21;
      pv_hist = '0;
      for (int i = 0; i < 9; i++) begin
         req_valid = (i < 3);
         step();
         pv_hist[i] = pixel_valid;
      end
      req_valid = 1'b0;
      pv_ones = $countones(pv_hist);
      chk("burst_count", pv_ones, 3);
      chk("burst_shape", pv_hist, 9'b000001110);

      // animation sequencer
      moving = 1'b1;
      step(); step(); step();
      chk("anim_3", frame, 0);
      step();
      chk("anim_4", frame, 1);
      step(); step(); step(); step();
      chk("anim_8", frame, 0);
      step(); step();
      moving = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("freeze_frame", frame, 0);
      chk("freeze_cnt", dut.anim_cnt, 2);
      moving = 1'b1;
      step();
      chk("resume_11", frame, 0);
      step();
      chk("anim_12", frame, F_THIRD);
      step(); step(); step(); step();
      chk("anim_16", frame, 0);
      step(); step(); step(); step();
      moving = 1'b0;
      chk("anim_20", frame, 1);

      // reset with a request in flight
      dir = DL; step(); dir = 4'b0000;
      x = 6'd15; y = 6'd21;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      rst = 1'b1;
      step();
      chk("rst_mid_pv0", pixel_valid, 0);
      rst = 1'b0;
      step();
      chk("rst_mid_pv1", pixel_valid, 0);
      step();
      chk("rst_mid_pv2", pixel_valid, 0);
      chk("rst_mid_frame", frame, 0);
      chk("rst_mid_dir", dut.dir_q, DR);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
